stream_mux_rr: RTL

- Parametrised successor of the team's 4:1 combinational mux.
- Selects one of N_CH valid/ready input streams of WIDTH bits onto a single registered output stream.
- Two selection modes: fixed select (sel_i) or round-robin arbitration.
- Sits between multiple producers and one consumer. Provides back-pressure and a one-entry output register, and reports the source channel of each output beat.

---
 rtl/stream_mux_rr.sv | 99 +++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N_CH-to-1 valid/ready stream mux with fixed-select or round-robin arbitration
// feeding a one-entry output register that also reports each beat's source channel.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_CH*WIDTH-1:0] data_i,
  input  logic [N_CH-1:0]       valid_i,
  output logic [N_CH-1:0]       ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [SEL_W-1:0]      ch_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [SEL_W-1:0] grant;
  logic             grantValid;
  logic             canAccept;
  logic             inXfer;
  int               idx;

  // Grant selection: fixed index in mode 0, first valid channel after last in mode 1.
  always_comb begin
    grant      = '0;
    grantValid = 1'b0;
    idx        = 0;
    if (!mode_i) begin
      if (int'(sel_i) < N_CH) begin
        grant      = sel_i;
        grantValid = valid_i[sel_i];
      end
    end else begin
      for (int i = 1; i <= N_CH; i++) begin
        idx = (int'(last_q) + i) % N_CH;
        if (!grantValid && valid_i[idx]) begin
          grant      = SEL_W'(idx);
          grantValid = 1'b1;
        end
      end
    end
  end

  // No handshake is offered while reset is held, since the register is being cleared.
  assign canAccept = !rst_i && (!valid_q || ready_i);
  assign inXfer    = canAccept && grantValid;

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      ready_o[k] = inXfer && (int'(grant) == k);
    end
  end

  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (inXfer) begin
      data_d  = data_i[int'(grant)*WIDTH +: WIDTH];
      ch_d    = grant;
      valid_d = 1'b1;
      if (mode_i) begin
        last_d = grant;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(N_CH - 1);
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = data_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;

endmodule
